posit_adder_arbiter: RTL

//  Shares one posit adder datapath (Optimised_PA, IN1/IN2 -> OUT) between two requesters.

---
 rtl/posit_adder_arbiter.sv | 121 ++++++++++++
 1 files changed

// File: rtl/posit_adder_arbiter.sv
// posit_adder_arbiter: lets two requesters share one external posit adder.
// Round-robin grant, valid/ready handshakes, registered adder operands,
// result captured LAT cycles after the operands are driven.
// Optional build macro: PA_ARB_NAR_BYPASS_EN (NaR operands short-circuit the adder).
module posit_adder_arbiter #(
  parameter int N   = 32,
  parameter int ES  = 4,
  parameter int LAT = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [N-1:0] rsp_sum,
  output logic [N-1:0] pa_in1,
  output logic [N-1:0] pa_in2,
  input  logic [N-1:0] pa_out,
  output logic         busy,
  output logic [15:0]  ops_done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  // ES only shapes the adder's arithmetic; it folds to zero here.
  localparam logic [1:0] LAT_M1 = 2'(LAT - 1 + 0 * ES);

  typedef struct packed {
    logic [N-1:0] a;
    logic [N-1:0] b;
  } opnd_t;

  logic [1:0] state;
  logic       last;    // requester granted on the previous accept
  logic       owner;
  logic [1:0] cnt;
  logic       grant0, grant1, accept;
  opnd_t      sel;

`ifdef PA_ARB_NAR_BYPASS_EN
  localparam logic [N-1:0] NAR = {1'b1, {(N-1){1'b0}}};
  logic acc_nar;
  assign acc_nar = (sel.a == NAR) || (sel.b == NAR);
`endif

  // Round-robin grant: a lone requester wins, a tie goes to the one not served last.
  always_comb begin
    grant0 = req0_valid & (~req1_valid | last);
    grant1 = req1_valid & (~req0_valid | ~last);
    sel.a  = grant1 ? req1_a : req0_a;
    sel.b  = grant1 ? req1_b : req0_b;
  end

  // Readys are forced low while reset is held so every output reads 0.
  assign req0_ready = ~reset & (state == IDLE) & grant0;
  assign req1_ready = ~reset & (state == IDLE) & grant1;
  assign accept     = (req0_valid & req0_ready) | (req1_valid & req1_ready);
  assign busy       = (state != IDLE);

  // Control FSM: accept -> wait on adder -> hold response until taken.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      last      <= 1'b1;
      owner     <= 1'b0;
      cnt       <= 2'd0;
      pa_in1    <= '0;
      pa_in2    <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_sum   <= '0;
      ops_done  <= 16'd0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          owner <= grant1;
          last  <= grant1;
`ifdef PA_ARB_NAR_BYPASS_EN
          if (acc_nar) begin
            rsp_sum   <= NAR;
            rsp_id    <= grant1;
            rsp_valid <= 1'b1;
            state     <= HOLD;
          end else
`endif
          begin
            pa_in1 <= sel.a;
            pa_in2 <= sel.b;
            cnt    <= LAT_M1;
            state  <= WAIT;
          end
        end
        WAIT: if (cnt == 2'd0) begin
          rsp_sum   <= pa_out;
          rsp_id    <= owner;
          rsp_valid <= 1'b1;
          state     <= HOLD;
        end else begin
          cnt <= cnt - 2'd1;
        end
        HOLD: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          ops_done  <= ops_done + 16'd1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
